// File: rtl/vote_window_pkg.sv
// Shared types and width helper for the two-button sliding-window vote controller.
package vote_window_pkg;

  typedef enum logic {S_COLLECT, S_ON} state_e;

  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// One-bit rising-edge detector; history presets to 1 so a level held through reset is not an edge.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/vote_window_ctrl.sv
// Collects yes/no button events into a sliding window and holds encender high
// once a full window carries enough yes votes, until finished arrives.
module vote_window_ctrl
  import vote_window_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int THRESH        = 2,
  parameter bit CLEAR_ON_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a,
  input  logic                       b,
  input  logic                       finished,
  output logic                       encender,
  output logic [DEPTH-1:0]           window,
  output logic [cntWidth(DEPTH)-1:0] ones_count,
  output logic [cntWidth(DEPTH)-1:0] fill
);

  localparam int            CW       = cntWidth(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  state_e           state_q;
  logic [DEPTH-1:0] window_q, window_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             pending_q, pending_d;
  logic             riseA, riseB, accept, fire;
  logic [CW-1:0]    onesSum;

  edge_pulse uEdgeA (.clk(clk), .rst(rst), .level_i(a), .rise_o(riseA));
  edge_pulse uEdgeB (.clk(clk), .rst(rst), .level_i(b), .rise_o(riseB));

  // Simultaneous presses are ambiguous, so only a lone edge counts as a vote.
  assign accept = (state_q == S_COLLECT) && (riseA ^ riseB);

  always_comb begin
    onesSum = '0;
    for (int i = 0; i < DEPTH; i++) onesSum = onesSum + CW'(window_q[i]);
  end

  // pending marks "a shift happened last edge"; firing needs fresh data so a retained window cannot refire.
  assign fire = (state_q == S_COLLECT) && pending_q && (fill_q == FULL) && (onesSum >= THRESH_C);

  always_comb begin
    window_d  = window_q;
    fill_d    = fill_q;
    pending_d = accept;
    if (accept) begin
      window_d = {window_q[DEPTH-2:0], riseA};
      fill_d   = (fill_q == FULL) ? FULL : fill_q + CW'(1);
    end
    if ((state_q == S_ON) && finished && CLEAR_ON_EXIT) begin
      window_d = '0;
      fill_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window_q  <= '0;
      fill_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      window_q  <= window_d;
      fill_q    <= fill_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_COLLECT;
      encender <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: if (fire) begin
          state_q  <= S_ON;
          encender <= 1'b1;
        end
        S_ON: if (finished) begin
          state_q  <= S_COLLECT;
          encender <= 1'b0;
        end
        default: begin
          state_q  <= S_COLLECT;
          encender <= 1'b0;
        end
      endcase
    end
  end

  assign window     = window_q;
  assign fill       = fill_q;
  assign ones_count = onesSum;

endmodule

// File: doc/vote_window_ctrl.md
# vote_window_ctrl

Parametrised successor to the two-button vote collector. Two push-button inputs are reduced to single-cycle rising-edge events. Each accepted event shifts a 1 (`a`) or a 0 (`b`) into a DEPTH-entry window. Once the window is full and holds at least THRESH ones, the control FSM asserts `encender` until `finished` is received. All logic runs on `clk`, with no derived or gated clocks.

## Interface
- `DEPTH`, default 4: window length in entries; legal range 2..32.
- `THRESH`, default 2: minimum number of ones required to fire; legal range 1..DEPTH.
- `CLEAR_ON_EXIT`, default 1: 1 clears the window and fill count when leaving ON; 0 retains them.
- `clk`  input  1  single system clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `a`  input  1  "yes" button, level, already synchronised and debounced.
- `b`  input  1  "no" button, level, already synchronised and debounced.
- `finished`  input  1  level; ends the ON phase.
- `encender`  output  1  registered; high while the FSM is in ON.
- `window`  output  DEPTH  shift contents; bit 0 is the newest entry.
- `ones_count`  output  $clog2(DEPTH+1)  population count of `window` (combinational).
- `fill`  output  $clog2(DEPTH+1)  number of valid entries, saturating at DEPTH.

## Operation
- Edge detection: `prev_a`/`prev_b` register `a`/`b` every cycle.
  - `rise_a = a & ~prev_a`; `rise_b = b & ~prev_b`.
- Accepted event (only in COLLECT):
  - `rise_a & ~rise_b` gives bit 1.
  - `rise_b & ~rise_a` gives bit 0.
  - Both rising in the same cycle: the event is dropped; no shift, `fill` unchanged.
- On an accepted event: `window <= {window[DEPTH-2:0], bit}`; `fill <= min(fill+1, DEPTH)`.
  - After saturation the oldest entry falls off (sliding window).
- `ones_count` is a full-width sum; it never overflows because its width covers DEPTH.
- FSM, two states:
  - COLLECT to ON when `fill == DEPTH && ones_count >= THRESH`, evaluated on registered values.
  - ON to COLLECT when `finished == 1`.
  - In COLLECT, `finished` is ignored.
- In ON:
  - All button events are ignored. The edge registers still track the inputs, so a button held across exit does not produce an event.
  - On the ON-to-COLLECT edge, if `CLEAR_ON_EXIT == 1`: `window <= 0`, `fill <= 0`. Otherwise both hold their values; re-entry then requires at least one new event, because the FSM re-evaluates only after a shift.
- Re-evaluation gating: a `pending` flag is set by each shift and cleared by the evaluation that follows it. COLLECT-to-ON requires `pending == 1`, which prevents an immediate refire after exit when CLEAR_ON_EXIT=0.

## Timing
- Reset values:
  - state = COLLECT; `encender` = 0; `window` = 0; `fill` = 0; `pending` = 0.
  - `prev_a` = `prev_b` = 1, so a button held through reset release produces no event.
- `rst` overrides everything in the same edge, including mid-ON and mid-shift.
- Latency from a press to the window update: `a` sampled high with `prev_a` = 0 at edge k updates `window` at edge k.
- Latency to `encender`: the FSM moves to ON at edge k+1, and `encender` is high in the cycle after edge k+1. Two edges from the press.
- Exit latency: `finished` high at edge m drops `encender` after edge m. The clear (if enabled) happens at the same edge.
- Press and `finished` in the same cycle while in ON: the press is ignored and the FSM exits.
- A held button produces exactly one event. A new event needs a low cycle first.

## Structure
- Package `vote_window_pkg`:
  - `typedef enum logic {S_COLLECT, S_ON} state_e`.
  - Helper constant function for the count width, `$clog2(DEPTH+1)`.
- Sub-module `edge_pulse`: one-bit rising-edge detector with synchronous reset preset to 1. Instantiated once for `a` and once for `b`.
- The window shifter, population count and FSM live in `vote_window_ctrl` itself.

## Test plan
All scenarios use DEPTH=4, THRESH=2, CLEAR_ON_EXIT=1.
1. Presses a,b,b,a (one-cycle pulses with gaps) -> `window` = 4'b1001, `fill` = 4, `ones_count` = 2; `encender` rises 2 edges after the last `a` rise.
2. Presses b,b,b,a -> `ones_count` = 1, `encender` stays 0. Then a second `a` -> `window` = 4'b0011, `encender` = 1.
3. `a` and `b` rising in the same cycle while `fill` = 2 -> `window` and `fill` unchanged. A following single `b` -> `fill` = 3.
4. In ON: `a` press alone -> no change. Then `a` press together with `finished` -> `encender` = 0 next cycle, `window` = 0, `fill` = 0, no refire.
5. `a` held high through reset release for 10 cycles -> `fill` stays 0. Release then press -> `fill` = 1, `window` = 4'b0001.
6. `rst` asserted while in ON with `window` = 4'b1111 -> next cycle `encender` = 0, `window` = 0, state COLLECT. Repeat scenario 1 with CLEAR_ON_EXIT=0 -> after exit `window` is retained and ON is re-entered only after the next event.
